// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
//   Shared types and the per-channel next-value rule for counter_bank.
//   next_count() works on MAX_W-bit operands so that a single function serves
//   every WIDTH. Callers zero-extend their value and limit and keep the low
//   WIDTH bits of the result.
package counter_bank_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             evt;
    } next_t;

    // Successor of value for one enabled count step. evt flags a boundary
    // event: leaving or sitting at LIMIT going up, or at 0 going down.
    function automatic next_t next_count(
        input logic [MAX_W-1:0] value,
        input logic [MAX_W-1:0] limit,
        input dir_e             dir,
        input mode_e            mode
    );
        next_t res;
        res.value = value;
        res.evt   = 1'b0;
        case (dir)
            UP: begin
                if (value == limit) begin
                    res.evt   = 1'b1;
                    res.value = (mode == SAT) ? limit : {MAX_W{1'b0}};
                end else begin
                    res.value = value + {{(MAX_W-1){1'b0}}, 1'b1};
                end
            end
            DOWN: begin
                if (value == {MAX_W{1'b0}}) begin
                    res.evt   = 1'b1;
                    res.value = (mode == SAT) ? {MAX_W{1'b0}} : limit;
                end else begin
                    res.value = value - {{(MAX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                res.value = value;
                res.evt   = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// counter_channel
//   One counter channel: clear > load > count > hold, with a limit that makes
//   it a modulo-(LIMIT+1) counter, wrap or saturate at the boundary, a
//   registered terminal-count pulse and a sticky overflow flag.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   en, dir_up        count enable, 1 = up / 0 = down
//   sat_mode          1 = saturate, 0 = wrap
//   clr, load         synchronous clear / load strobe
//   load_val          load value, clamped to LIMIT
//   ovf_clr           clears ovf (a coincident boundary event wins)
//   count, tc, ovf    registered counter value, event pulse, sticky flag
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir_up,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;
    logic [MAX_W-1:0] value_ext_s;
    logic [MAX_W-1:0] limit_ext_s;
    next_t            nxt_s;
    logic [WIDTH-1:0] load_sat_s;
    logic [WIDTH-1:0] count_d_s;
    logic             evt_s;

    // Widen value and limit for the shared step function.
    always_comb begin
        value_ext_s              = {MAX_W{1'b0}};
        value_ext_s[WIDTH-1:0]   = count_r;
        limit_ext_s              = {MAX_W{1'b0}};
        limit_ext_s[WIDTH-1:0]   = LIMIT;
        nxt_s = next_count(value_ext_s, limit_ext_s, dir_e'(dir_up), mode_e'(sat_mode));
    end

    // Upper bits of the step result are always zero because value <= LIMIT.
    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi_s;
        assign unused_hi_s = |nxt_s.value[MAX_W-1:WIDTH];
    end

    // Next value with clr > load > count > hold; clr/load mask the event.
    always_comb begin
        load_sat_s = (load_val > LIMIT) ? LIMIT : load_val;
        if (clr) begin
            count_d_s = {WIDTH{1'b0}};
            evt_s     = 1'b0;
        end else if (load) begin
            count_d_s = load_sat_s;
            evt_s     = 1'b0;
        end else if (en) begin
            count_d_s = nxt_s.value[WIDTH-1:0];
            evt_s     = nxt_s.evt;
        end else begin
            count_d_s = count_r;
            evt_s     = 1'b0;
        end
    end

    // Counter, tc pulse and sticky ovf (set beats clear on the same edge).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_d_s;
            tc_r    <= evt_s;
            ovf_r   <= evt_s | (ovf_r & ~ovf_clr);
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/counter_bank.sv
// counter_bank
//   NUM_CH independent counter_channel instances on flattened buses, plus a
//   valid/ready read port returning any channel's value (one request in
//   flight; out-of-range channel returns data 0 with rd_rsp_err set).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   en/dir_up/sat_mode/clr/load      per-channel controls, NUM_CH bits each
//   load_val, count                  channel i at [i*WIDTH +: WIDTH]
//   tc, ovf, ovf_clr                 per-channel pulse, sticky flag, flag clear
//   rd_req_valid/ready, rd_chan      read request
//   rd_rsp_valid/ready, rd_rsp_data, rd_rsp_err   read response
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int               NUM_CH = 4,
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] LIMIT  = {WIDTH{1'b1}},
    localparam int              CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       dir_up,
    input  logic [NUM_CH-1:0]       sat_mode,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf,
    input  logic [NUM_CH-1:0]       ovf_clr,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [CH_W-1:0]         rd_chan,
    output logic                    rd_rsp_valid,
    input  logic                    rd_rsp_ready,
    output logic [WIDTH-1:0]        rd_rsp_data,
    output logic                    rd_rsp_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [WIDTH-1:0] count_s [NUM_CH];
    logic [WIDTH-1:0] sel_data_s;
    logic             chan_err_s;
    logic [0:0]       state_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH),
            .LIMIT (LIMIT)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .dir_up   (dir_up[i]),
            .sat_mode (sat_mode[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .ovf_clr  (ovf_clr[i]),
            .count    (count_s[i]),
            .tc       (tc[i]),
            .ovf      (ovf[i])
        );
        assign count[i*WIDTH +: WIDTH] = count_s[i];
    end

    // Read mux over the pre-update counts; indices past NUM_CH select nothing.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        chan_err_s = (32'(rd_chan) >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_chan == CH_W'(i)) begin
                sel_data_s = count_s[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Read-port FSM: IDLE accepts a request, RESP holds it until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rsp_data_r <= {WIDTH{1'b0}};
            rsp_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_req_valid) begin
                        state_r    <= ST_RESP;
                        rsp_data_r <= chan_err_s ? {WIDTH{1'b0}} : sel_data_s;
                        rsp_err_r  <= chan_err_s;
                    end
                end
                ST_RESP: begin
                    if (rd_rsp_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Ready and valid decode straight from the state flop.
    assign rd_req_ready = (state_r == ST_IDLE);
    assign rd_rsp_valid = (state_r == ST_RESP);
    assign rd_rsp_data  = rsp_data_r;
    assign rd_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank
//   Directed scenarios followed by random stimulus against a behavioural
//   model. The driver updates the model on each rising edge and queues the
//   expected outputs; a monitor on the falling edge pops and compares.
//   NUM_CH = 5 so that out-of-range read indices 5..7 exist on a 3-bit rd_chan.
module tb_counter_bank;

    localparam int NC  = 5;
    localparam int W   = 4;
    localparam int LIM = 9;
    localparam int CW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   en, dir_up, sat_mode, clr, load, ovf_clr;
    logic [NC*W-1:0] load_val;
    logic [NC*W-1:0] count;
    logic [NC-1:0]   tc, ovf;
    logic            rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
    logic [CW-1:0]   rd_chan;
    logic [W-1:0]    rd_rsp_data;

    counter_bank #(.NUM_CH(NC), .WIDTH(W), .LIMIT(W'(LIM))) dut (
        .clk(clk), .reset(reset), .en(en), .dir_up(dir_up), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .count(count), .tc(tc),
        .ovf(ovf), .ovf_clr(ovf_clr), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_chan(rd_chan), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC*W-1:0] cnt;
        logic [NC-1:0]   tc;
        logic [NC-1:0]   ovf;
        logic            busy;
    } st_t;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    st_t  st_q[$];
    rsp_t rsp_q[$];

    int          m_cnt [NC];
    bit [NC-1:0] m_tc, m_ovf;
    bit          m_busy;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_state();
        st_t s;
        for (int i = 0; i < NC; i++) s.cnt[i*W +: W] = W'(m_cnt[i]);
        s.tc   = m_tc;
        s.ovf  = m_ovf;
        s.busy = m_busy;
        st_q.push_back(s);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_tc   = '0;
        m_ovf  = '0;
        m_busy = 1'b0;
        rsp_q.delete();
    endtask

    // Apply the counting and read rules for one rising edge.
    task automatic model_edge();
        int   v, n;
        bit   ev;
        rsp_t r;
        if (reset) begin
            model_clear();
        end else begin
            if (!m_busy && rd_req_valid) begin
                r.err  = (int'(rd_chan) >= NC);
                r.data = '0;
                if (!r.err) r.data = W'(m_cnt[int'(rd_chan)]);
                rsp_q.push_back(r);
                m_busy = 1'b1;
            end else if (m_busy && rd_rsp_ready) begin
                m_busy = 1'b0;
            end
            for (int i = 0; i < NC; i++) begin
                v  = m_cnt[i];
                n  = v;
                ev = 1'b0;
                if (clr[i]) begin
                    n = 0;
                end else if (load[i]) begin
                    n = int'(load_val[i*W +: W]);
                    if (n > LIM) n = LIM;
                end else if (en[i]) begin
                    if (dir_up[i]) begin
                        ev = (v == LIM);
                        n  = sat_mode[i] ? ((v + 1 > LIM) ? LIM : v + 1) : (v + 1) % (LIM + 1);
                    end else begin
                        ev = (v == 0);
                        n  = sat_mode[i] ? ((v == 0) ? 0 : v - 1) : (v + LIM) % (LIM + 1);
                    end
                end
                m_cnt[i]  = n;
                m_tc[i]   = ev;
                m_ovf[i]  = ev | (m_ovf[i] & ~ovf_clr[i]);
            end
        end
        push_state();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = '0; dir_up = '0; sat_mode = '0; clr = '0; load = '0; ovf_clr = '0;
        load_val = '0; rd_req_valid = 1'b0; rd_chan = '0; rd_rsp_ready = 1'b1;
    endtask

    function automatic logic [W-1:0] cnt_of(input int ch);
        return count[ch*W +: W];
    endfunction

    // Monitor: compare the queued expectation and any presented response.
    always @(negedge clk) begin
        st_t s;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            for (int i = 0; i < NC; i++)
                chk($sformatf("count[%0d]", i), count[i*W +: W], s.cnt[i*W +: W]);
            chk("tc", tc, s.tc);
            chk("ovf", ovf, s.ovf);
            chk("rd_rsp_valid", rd_rsp_valid, s.busy);
            chk("rd_req_ready", rd_req_ready, !s.busy);
        end
        if (rd_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rd_rsp_data", rd_rsp_data, rsp_q[0].data);
                chk("rd_rsp_err", rd_rsp_err, rsp_q[0].err);
                if (rd_rsp_ready) void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_clear();
        step();
        step();
        chk("reset_count", count, 0);
        chk("reset_req_ready", rd_req_ready, 1);
        chk("reset_rsp_valid", rd_rsp_valid, 0);
        reset = 1'b0;

        // Async reset mid-count with a read outstanding.
        load[0] = 1'b1; load_val[0 +: W] = W'(7);
        step();
        load = '0; en[0] = 1'b1; dir_up[0] = 1'b1;
        rd_req_valid = 1'b1; rd_chan = CW'(0); rd_rsp_ready = 1'b0;
        step();
        rd_req_valid = 1'b0;
        step();
        chk("pre_reset_count0", cnt_of(0), 9);
        reset = 1'b1;
        #1;
        chk("async_count0", cnt_of(0), 0);
        chk("async_ovf", ovf, 0);
        chk("async_rsp_valid", rd_rsp_valid, 0);
        st_q.delete();
        model_clear();
        push_state();
        #5;
        reset = 1'b0;
        idle_inputs();

        // Wrap on channel 1: 8 -> 9 -> 0 -> 1.
        load[1] = 1'b1; load_val[1*W +: W] = W'(8);
        step();
        load = '0; en[1] = 1'b1; dir_up[1] = 1'b1;
        step();
        chk("wrap_9", cnt_of(1), 9);
        chk("wrap_tc_before", tc[1], 0);
        step();
        chk("wrap_0", cnt_of(1), 0);
        chk("wrap_tc", tc[1], 1);
        step();
        chk("wrap_1", cnt_of(1), 1);
        chk("wrap_tc_after", tc[1], 0);
        chk("wrap_ovf", ovf[1], 1);
        en = '0; ovf_clr[1] = 1'b1;
        step();
        chk("ovf_cleared", ovf[1], 0);
        ovf_clr = '0;

        // Saturate down on channel 3 from 1.
        load[3] = 1'b1; load_val[3*W +: W] = W'(1);
        step();
        load = '0; en[3] = 1'b1; dir_up[3] = 1'b0; sat_mode[3] = 1'b1;
        step();
        chk("sat_tc_first", tc[3], 0);
        step();
        chk("sat_tc_second", tc[3], 1);
        step();
        chk("sat_tc_third", tc[3], 1);
        chk("sat_count", cnt_of(3), 0);
        en = '0; sat_mode = '0;

        // Priority and clamped load on channel 4.
        clr[4] = 1'b1; load[4] = 1'b1; load_val[4*W +: W] = W'(5); en[4] = 1'b1; dir_up[4] = 1'b1;
        step();
        chk("prio_clr", cnt_of(4), 0);
        clr = '0; en = '0; load_val[4*W +: W] = W'(12);
        step();
        chk("load_clamp", cnt_of(4), 9);
        chk("load_no_tc", tc[4], 0);

        // Boundary event coinciding with ovf_clr keeps ovf set.
        load = '0; en[4] = 1'b1; ovf_clr[4] = 1'b1;
        step();
        chk("ovf_set_wins", ovf[4], 1);
        idle_inputs();

        // Read handshake on channel 2 while it counts.
        load[2] = 1'b1; load_val[2*W +: W] = W'(7);
        step();
        load = '0; en[2] = 1'b1; dir_up[2] = 1'b1;
        rd_req_valid = 1'b1; rd_chan = CW'(2); rd_rsp_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_valid", rd_rsp_valid, 1);
            chk("hold_data", rd_rsp_data, 7);
            chk("hold_ready", rd_req_ready, 0);
        end
        rd_rsp_ready = 1'b1; rd_req_valid = 1'b0;
        step();
        chk("ready_after_hs", rd_req_ready, 1);
        rd_req_valid = 1'b1; rd_chan = CW'(5); rd_rsp_ready = 1'b0;
        step();
        rd_req_valid = 1'b0;
        chk("err_flag", rd_rsp_err, 1);
        chk("err_data", rd_rsp_data, 0);
        rd_rsp_ready = 1'b1;
        step();
        idle_inputs();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            en       = NC'($urandom());
            dir_up   = NC'($urandom());
            sat_mode = NC'($urandom());
            load_val = (NC*W)'($urandom());
            for (int i = 0; i < NC; i++) begin
                clr[i]     = ($urandom_range(0, 15) == 0);
                load[i]    = ($urandom_range(0, 11) == 0);
                ovf_clr[i] = ($urandom_range(0, 7) == 0);
            end
            rd_req_valid = 1'($urandom());
            rd_chan      = CW'($urandom());
            rd_rsp_ready = 1'($urandom());
            step();
        end

        idle_inputs();
        repeat (3) step();
        @(negedge clk);
        #1;
        chk("state_queue_drained", st_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
